// File: rtl/hex_ascii_uart_pkg.sv
// ============================================================================
// Module      : hex_ascii_uart_pkg
// Description : Shared types, ASCII constants and nibble conversion for the
//               hex/ASCII UART transmit path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hex_ascii_uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_BIT = 2'd1,
    DATA_BITS = 2'd2,
    STOP_BIT  = 2'd3
  } state_t;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_A  = 8'h41;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_E  = 8'h45;
  localparam logic [7:0] ASCII_R  = 8'h52;
  localparam logic [7:0] ASCII_O  = 8'h4F;
  localparam logic [7:0] ASCII_V  = 8'h56;
  localparam logic [7:0] ASCII_F  = 8'h46;

  localparam int MSG_MAX_LEN = 6;

  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return ASCII_0 + {4'd0, nib};
    end
    return ASCII_A + {4'd0, nib} - 8'd10;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_byte_serializer.sv
// ============================================================================
// Module      : uart_byte_serializer
// Description : 8N1 serializer; accepts a back-to-back load in the last cycle
//               of a stop bit so consecutive characters have no idle gap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_byte_serializer
  import hex_ascii_uart_pkg::*;
#(
  parameter int BIT_CYCLES = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] data_byte,
  output logic       tx,
  output logic       byte_done
);

  localparam int CNT_W = $clog2(BIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             w_bit_end;

  assign w_bit_end = (r_cnt == CNT_LAST);
  // Flags the edge that closes the stop bit, so the sequencer can chain a load.
  assign byte_done = (r_state == STOP_BIT) && w_bit_end;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'd0;
      tx        <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (load) begin
            r_state <= START_BIT;
            r_shift <= data_byte;
            tx      <= 1'b0;
          end
        end
        START_BIT: begin
          if (w_bit_end) begin
            r_cnt     <= '0;
            r_state   <= DATA_BITS;
            r_bit_idx <= 3'd0;
            tx        <= r_shift[0];
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DATA_BITS: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
              r_state <= STOP_BIT;
              tx      <= 1'b1;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
              r_shift   <= {1'b0, r_shift[7:1]};
              tx        <= r_shift[1];
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        STOP_BIT: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (load) begin
              r_state <= START_BIT;
              r_shift <= data_byte;
              tx      <= 1'b0;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          tx      <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/hex_ascii_uart_tx.sv
// ============================================================================
// Module      : hex_ascii_uart_tx
// Description : Prints a 16-bit result as 4 uppercase hex digits + CR LF over
//               8N1 UART. Optional macro HEX_ASCII_STATUS_EN adds ERR/OVF text.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hex_ascii_uart_tx
  import hex_ascii_uart_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] data,
  input  logic        overflow,
  input  logic [3:0]  error,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int BIT_CYCLES = CLK_HZ / BAUD;
  localparam int IDX_W      = $clog2(MSG_MAX_LEN);

  typedef logic [IDX_W-1:0] idx_t;
  localparam idx_t LAST_FULL = idx_t'(MSG_MAX_LEN - 1);

  function automatic logic [7:0] hex_char(input logic [15:0] d, input idx_t idx);
    case (int'(idx))
      0:       return nibble_to_ascii(d[15:12]);
      1:       return nibble_to_ascii(d[11:8]);
      2:       return nibble_to_ascii(d[7:4]);
      3:       return nibble_to_ascii(d[3:0]);
      4:       return ASCII_CR;
      default: return ASCII_LF;
    endcase
  endfunction

`ifdef HEX_ASCII_STATUS_EN
  // Error code outranks overflow; both replace the hex digits entirely.
  function automatic logic [7:0] msg_char(input logic [15:0] d, input logic ovf,
                                          input logic [3:0] err, input idx_t idx);
    if (err != 4'd0) begin
      case (int'(idx))
        0:       return ASCII_E;
        1:       return ASCII_R;
        2:       return ASCII_R;
        3:       return nibble_to_ascii(err);
        4:       return ASCII_CR;
        default: return ASCII_LF;
      endcase
    end else if (ovf) begin
      case (int'(idx))
        0:       return ASCII_O;
        1:       return ASCII_V;
        2:       return ASCII_F;
        3:       return ASCII_CR;
        default: return ASCII_LF;
      endcase
    end
    return hex_char(d, idx);
  endfunction
`endif

  logic [15:0] r_data;
  idx_t        r_char_idx;
  logic        r_busy;
  logic        r_done;
  idx_t        w_last_idx;
  idx_t        w_next_idx;
  logic [7:0]  w_byte;
  logic        w_accept;
  logic        w_load;
  logic        w_byte_done;

`ifdef HEX_ASCII_STATUS_EN
  logic        r_ovf;
  logic [3:0]  r_err;
  idx_t        r_last_idx;
  assign w_last_idx = r_last_idx;
`else
  logic        w_unused_status;
  assign w_unused_status = overflow ^ (|error);
  assign w_last_idx      = LAST_FULL;
`endif

  // The done cycle also blocks acceptance; earliest restart is one cycle later.
  assign w_accept   = start && !r_busy && !r_done;
  assign w_next_idx = idx_t'(r_char_idx + 1'b1);
  assign w_load     = w_accept || (r_busy && w_byte_done && (r_char_idx != w_last_idx));

  always_comb begin
    w_byte = 8'd0;
`ifdef HEX_ASCII_STATUS_EN
    if (r_busy) w_byte = msg_char(r_data, r_ovf, r_err, w_next_idx);
    else        w_byte = msg_char(data, overflow, error, '0);
`else
    if (r_busy) w_byte = hex_char(r_data, w_next_idx);
    else        w_byte = hex_char(data, '0);
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_data     <= 16'd0;
      r_char_idx <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef HEX_ASCII_STATUS_EN
      r_ovf      <= 1'b0;
      r_err      <= 4'd0;
      r_last_idx <= LAST_FULL;
`endif
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_busy     <= 1'b1;
        r_data     <= data;
        r_char_idx <= '0;
`ifdef HEX_ASCII_STATUS_EN
        r_ovf      <= overflow;
        r_err      <= error;
        r_last_idx <= ((error == 4'd0) && overflow) ? idx_t'(4) : LAST_FULL;
`endif
      end else if (r_busy && w_byte_done) begin
        if (r_char_idx == w_last_idx) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end else begin
          r_char_idx <= w_next_idx;
        end
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;

  uart_byte_serializer #(
    .BIT_CYCLES (BIT_CYCLES)
  ) u_serializer (
    .clock     (clock),
    .reset     (reset),
    .load      (w_load),
    .data_byte (w_byte),
    .tx        (tx),
    .byte_done (w_byte_done)
  );

endmodule

`default_nettype wire

// File: tb/tb_hex_ascii_uart_tx.sv
// ============================================================================
// Module      : tb_hex_ascii_uart_tx
// Description : Self-checking bench for hex_ascii_uart_tx with a message-level
//               reference model (honours HEX_ASCII_STATUS_EN when defined).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_hex_ascii_uart_tx;

  localparam int CLK_HZ = 1000000;
  localparam int BAUD   = 100000;
  localparam int BITC   = CLK_HZ / BAUD;
`ifdef HEX_ASCII_STATUS_EN
  localparam bit STATUS_EN = 1'b1;
`else
  localparam bit STATUS_EN = 1'b0;
`endif

  logic        clock    = 1'b0;
  logic        reset    = 1'b1;
  logic        start    = 1'b0;
  logic [15:0] data     = 16'd0;
  logic        overflow = 1'b0;
  logic [3:0]  error    = 4'd0;
  logic        tx;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  hex_ascii_uart_tx #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .data     (data),
    .overflow (overflow),
    .error    (error),
    .tx       (tx),
    .busy     (busy),
    .done     (done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] hexd(input logic [3:0] n);
    return 8'((n < 10) ? 48 + int'(n) : 55 + int'(n));
  endfunction

  // Expected text of one message, straight from the console format rules.
  function automatic int model_msg(input logic [15:0] d, input logic ovf,
                                   input logic [3:0] err, output logic [7:0] m [6]);
    for (int i = 0; i < 6; i++) m[i] = 8'd0;
    if (STATUS_EN && err != 4'd0) begin
      m[0] = "E"; m[1] = "R"; m[2] = "R"; m[3] = hexd(err); m[4] = 8'd13; m[5] = 8'd10;
      return 6;
    end
    if (STATUS_EN && ovf) begin
      m[0] = "O"; m[1] = "V"; m[2] = "F"; m[3] = 8'd13; m[4] = 8'd10;
      return 5;
    end
    for (int i = 0; i < 4; i++) m[i] = hexd(4'((d >> (12 - 4 * i)) & 16'hF));
    m[4] = 8'd13;
    m[5] = 8'd10;
    return 6;
  endfunction

  // Entered #1 after some edge; leaves #1 after the accepting edge.
  task automatic issue_start(input string tag, input logic [15:0] d, input logic ovf,
                             input logic [3:0] err);
    start = 1'b1; data = d; overflow = ovf; error = err;
    @(posedge clock); #1;
    start = 1'b0;
    data = 16'($urandom); overflow = 1'($urandom); error = 4'($urandom);
    chk({tag, "_accept_busy"}, busy, 1'b1);
    chk({tag, "_start_bit"}, tx, 1'b0);
  endtask

  // Samples every cycle of the message; ends in the done cycle.
  task automatic check_msg(input string tag, input logic [15:0] d, input logic ovf,
                           input logic [3:0] err, input int inject_at);
    logic [7:0] m [6];
    logic       samp [600];
    logic [7:0] got;
    logic       expb;
    int         len, total, busy_bad, done_bad, bad;
    len = model_msg(d, ovf, err, m);
    total = len * 10 * BITC;
    busy_bad = 0;
    done_bad = 0;
    for (int k = 0; k < total; k++) begin
      samp[k] = tx;
      if (busy !== 1'b1) busy_bad++;
      if (done !== 1'b0) done_bad++;
      if (k == inject_at) begin
        start = 1'b1; data = 16'h1234;
      end else if (k == inject_at + 1) begin
        start = 1'b0;
      end
      @(posedge clock); #1;
    end
    chk({tag, "_busy_held"}, busy_bad, 0);
    chk({tag, "_no_early_done"}, done_bad, 0);
    for (int c = 0; c < len; c++) begin
      got = 8'd0;
      for (int b = 0; b < 10; b++) begin
        expb = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : m[c][b-1];
        bad = 0;
        for (int j = 0; j < BITC; j++)
          if (samp[(c * 10 + b) * BITC + j] !== expb) bad++;
        chk($sformatf("%s_c%0d_b%0d_badcycles", tag, c, b), bad, 0);
        if (b >= 1 && b <= 8) got[b-1] = samp[(c * 10 + b) * BITC + BITC / 2];
      end
      chk($sformatf("%s_char%0d", tag, c), got, m[c]);
    end
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_busy_fall"}, busy, 1'b0);
    chk({tag, "_tx_idle"}, tx, 1'b1);
  endtask

  task automatic quiet(input string tag, input int cycles);
    int bad;
    bad = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clock); #1;
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    chk({tag, "_quiet"}, bad, 0);
  endtask

  initial begin
    logic [15:0] rd;
    logic        rovf;
    logic [3:0]  rerr;

    // Reset state and idle line
    repeat (3) @(posedge clock);
    #1;
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    quiet("post_reset", 100);

    // 1A2F, then a start in the done cycle (rejected) held into the next (accepted)
    issue_start("m1a2f", 16'h1A2F, 1'b0, 4'd0);
    check_msg("m1a2f", 16'h1A2F, 1'b0, 4'd0, -1);
    start = 1'b1; data = 16'h0000; overflow = 1'b0; error = 4'd0;
    @(posedge clock); #1;
    chk("done_cycle_reject", busy, 1'b0);
    chk("done_single_pulse", done, 1'b0);
    issue_start("m0000", 16'h0000, 1'b0, 4'd0);
    check_msg("m0000", 16'h0000, 1'b0, 4'd0, -1);
    @(posedge clock); #1;
    issue_start("mffff", 16'hFFFF, 1'b0, 4'd0);
    check_msg("mffff", 16'hFFFF, 1'b0, 4'd0, -1);

    // Start while busy is ignored
    quiet("gap1", 5);
    issue_start("ign", 16'hBEEF, 1'b0, 4'd0);
    check_msg("ign", 16'hBEEF, 1'b0, 4'd0, 250);
    quiet("ign_no_second", 100);

    // Asynchronous reset mid-message
    issue_start("rst", 16'h1A2F, 1'b0, 4'd0);
    repeat (137) @(posedge clock);
    #1;
    chk("pre_reset_tx", tx, 1'b0);
    reset = 1'b1;
    #1;
    chk("async_rst_tx", tx, 1'b1);
    chk("async_rst_busy", busy, 1'b0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    rd = 16'($urandom);
    issue_start("after_rst", rd, 1'b0, 4'd0);
    check_msg("after_rst", rd, 1'b0, 4'd0, -1);

    // Random values and status inputs
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      rd   = 16'($urandom);
      rovf = 1'($urandom_range(0, 1));
      rerr = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      issue_start($sformatf("rnd%0d", i), rd, rovf, rerr);
      check_msg($sformatf("rnd%0d", i), rd, rovf, rerr, -1);
    end

    // Status messages (hex digits of data when the feature is absent)
    @(posedge clock); #1;
    rd = 16'($urandom);
    issue_start("err3", rd, 1'b1, 4'h3);
    check_msg("err3", rd, 1'b1, 4'h3, -1);
    @(posedge clock); #1;
    rd = 16'($urandom);
    issue_start("ovf", rd, 1'b1, 4'h0);
    check_msg("ovf", rd, 1'b1, 4'h0, -1);
    quiet("final", 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hex_ascii_uart_tx.md
Name: hex_ascii_uart_tx

Overview:
- Transmit side of the UART calculator console; the counterpart of the ASCII-receive/decode path.
- Takes a 16-bit result and sends it to the host terminal as human-readable text: 4 uppercase hex digits followed by CR LF, 8N1 framing.
- Sits between the calculator result/newresult outputs and the board tx pin, in place of raw two-byte binary output.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz
BAUD, 115200, line rate; BIT_CYCLES = CLK_HZ / BAUD (integer division), must be >= 2

Ports:
clock     input   1   system clock, all state on rising edge
reset     input   1   asynchronous, active-high; clears all state
start     input   1   one-cycle request to send the current data
data      input   16  value to print; sampled when start is accepted
overflow  input   1   status flag; sampled with data (used only under the optional feature)
error     input   4   status code; sampled with data (used only under the optional feature)
tx        output  1   UART line, idle high
busy      output  1   high from the cycle after acceptance until the message ends
done      output  1   one-cycle pulse when the last stop bit completes

Behaviour:
- Reset values: tx=1, busy=0, done=0; FSM=IDLE; counters=0. Reset mid-message aborts immediately (async); no partial frame resumes.
- Accept: start=1 while busy=0 latches data/overflow/error. Next cycle: busy=1, first start bit driven.
- start while busy=1: ignored, no queueing; the latched value is unaffected.
- Message (default): chars 0..3 = hex nibbles data[15:12], [11:8], [7:4], [3:0].
  - Nibble 0-9 -> 0x30-0x39; A-F -> 0x41-0x46.
  - char 4 = 0x0D; char 5 = 0x0A.
- Frame per char: start bit 0, 8 data bits LSB first, stop bit 1. Each bit held exactly BIT_CYCLES cycles. No idle gap between chars.
- FSM: IDLE -> START_BIT -> DATA_BITS (bit_idx 0..7) -> STOP_BIT.
  - From STOP_BIT: next char's START_BIT if char_idx < last, else IDLE.
  - Baud counter counts 0..BIT_CYCLES-1 and wraps on each bit boundary.
- Total message = 6 chars x 10 bits x BIT_CYCLES cycles.
- End of message: done=1 and busy=0 in the same cycle that the final stop bit period ends; FSM returns to IDLE.
- start asserted in that done cycle: not accepted (busy is computed from registered state). Earliest accept is the following cycle.
- tx is driven from a register (glitch-free).

Optional Feature:
- Macro: HEX_ASCII_STATUS_EN
- Defined: status is checked at acceptance, highest priority first.
  - error != 0: send "ERR" + hex(error) + CR LF (0x45 0x52 0x52 h 0x0D 0x0A).
  - else overflow = 1: send "OVF" + CR LF (0x4F 0x56 0x46 0x0D 0x0A); 5 chars, done follows the 5th stop bit.
  - else: normal message.
- Not defined: overflow and error are unused; message is always the 4 hex digits + CR LF.

Decomposition:
- Package hex_ascii_uart_pkg holds:
  - state typedef enum {IDLE, START_BIT, DATA_BITS, STOP_BIT}
  - ASCII constants: ASCII_0, ASCII_A, ASCII_CR, ASCII_LF, ASCII_E, ASCII_R, ASCII_O, ASCII_V, ASCII_F
  - MSG_MAX_LEN = 6
  - function nibble_to_ascii
- One sub-module is natural: uart_byte_serializer.
  - Inputs: byte, load; outputs: tx, byte_done; BIT_CYCLES parameter.
  - The top of this block sequences the characters.

Test Plan:
- CLK_HZ=1000000, BAUD=100000 (10 cycles/bit); reset held then released -> tx=1, busy=0, done=0; no edges on tx for 100 cycles.
- start with data=16'h1A2F -> tx decodes 0x31 0x41 0x32 0x46 0x0D 0x0A; each bit exactly 10 cycles; done pulses once at cycle 600 after acceptance, busy falls the same cycle.
- data=16'h0000, then data=16'hFFFF -> "0000\r\n", then "FFFF\r\n"; second start is issued the cycle after done and is accepted.
- start pulsed again at cycle 250 of a message with data=16'h1234 -> ignored; original bytes complete unchanged; no second message.
- reset asserted at cycle 137 of a message -> tx=1 and busy=0 the same cycle; a new start after release sends a full, correct message.
- With HEX_ASCII_STATUS_EN: error=4'h3 -> "ERR3\r\n"; error=0 with overflow=1 -> "OVF\r\n", done at cycle 500; without the macro, same stimulus -> hex digits of data.
